// File: rtl/uno_pkg.sv
// Shared types and Q4.8 polynomial coefficient tables for the uno sequencer.
// MAC_BW defaults to 12 unless the build defines it.
`ifndef MAC_BW
`define MAC_BW 12
`endif

package uno_pkg;

    typedef enum logic [1:0] {
        OP_MAC = 2'b00,
        OP_DIV = 2'b01,
        OP_EXP = 2'b10,
        OP_LOG = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_CAPT  = 2'b10,
        S_HOLD  = 2'b11
    } state_t;

    localparam int COEFF_W = 12;
    localparam int MAX_TERMS = 8;

    // Row per op, column per issue cycle k; exp is the 1/k! series, div/log fall by 4x per term.
    localparam logic [COEFF_W-1:0] COEFF [4][MAX_TERMS] = '{
        '{12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000},
        '{12'h100, 12'h040, 12'h010, 12'h004, 12'h001, 12'h000, 12'h000, 12'h000},
        '{12'h100, 12'h100, 12'h080, 12'h02B, 12'h00B, 12'h002, 12'h000, 12'h000},
        '{12'h100, 12'h040, 12'h010, 12'h004, 12'h001, 12'h000, 12'h000, 12'h000}
    };

    // Index of the final issue cycle: a MAC issues once, every other op issues TERMS times.
    function automatic logic [2:0] last_k(input op_t op, input int terms);
        return (op == OP_MAC) ? 3'd0 : 3'(terms - 1);
    endfunction

endpackage

// File: rtl/uno_coeff_rom.sv
// Combinational coefficient lookup: COEFF[op][k] resized to the operand width.
module uno_coeff_rom
    import uno_pkg::*;
#(
    parameter int MAC_BW = `MAC_BW
) (
    input  op_t               op,
    input  logic [2:0]        k,
    output logic [MAC_BW-1:0] coeff
);

    always_comb begin
        coeff = MAC_BW'(COEFF[op][k]);
    end

endmodule

// File: rtl/uno_seq.sv
// Request sequencer for the uno MAC datapath: issues 1 or TERMS cycles, captures the result, holds it.
// Optional UNO_SEQ_PERF_EN adds a saturating completed-result counter on perf_cnt.
module uno_seq
    import uno_pkg::*;
#(
    parameter int TERMS  = 4,
    parameter int MAC_BW = `MAC_BW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [MAC_BW-1:0]     req_x,
    input  logic [MAC_BW-1:0]     req_y,
    input  logic [2*MAC_BW-1:0]   req_z,
    output logic [1:0]            u_op,
    output logic [MAC_BW-1:0]     u_x,
    output logic [MAC_BW-1:0]     u_y,
    output logic [2*MAC_BW-1:0]   u_z,
    output logic [MAC_BW-1:0]     u_coeff,
    output logic                  u_first,
    output logic                  u_last,
    output logic                  u_acc_en,
    input  logic [2*MAC_BW+3:0]   u_out,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [2*MAC_BW+3:0]   res_data,
`ifdef UNO_SEQ_PERF_EN
    output logic [15:0]           perf_cnt,
`endif
    output state_t                dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
    // valid-side payload must be stable while waiting, ready never depends on valid.

    state_t              state, state_next;
    logic [2:0]          k;
    op_t                 op_r;
    logic [MAC_BW-1:0]   x_r, y_r;
    logic [2*MAC_BW-1:0] z_r;
    logic [MAC_BW-1:0]   rom_coeff;
    logic                req_fire, res_fire, issue_end;

    assign req_fire  = req_valid && req_ready;
    assign res_fire  = res_valid && res_ready;
    assign issue_end = (state == S_ISSUE) && (k == last_k(op_r, TERMS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        res_valid  = 1'b0;
        u_first    = 1'b0;
        u_last     = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = S_ISSUE;
            end
            S_ISSUE: begin
                u_first = (k == 3'd0);
                u_last  = issue_end;
                if (issue_end) state_next = S_CAPT;
            end
            S_CAPT: begin
                state_next = S_HOLD;
            end
            S_HOLD: begin
                res_valid = 1'b1;
                if (res_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k <= 3'd0;
        end else if (state == S_ISSUE && !issue_end) begin
            k <= k + 3'd1;
        end else begin
            k <= 3'd0;
        end
    end

    // Operands are zeroed on leaving HOLD so the datapath sees zeros while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r <= OP_MAC;
            x_r  <= '0;
            y_r  <= '0;
            z_r  <= '0;
        end else if (req_fire) begin
            op_r <= op_t'(req_op);
            x_r  <= req_x;
            y_r  <= req_y;
            z_r  <= req_z;
        end else if (res_fire) begin
            op_r <= OP_MAC;
            x_r  <= '0;
            y_r  <= '0;
            z_r  <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_data <= '0;
        end else if (state == S_CAPT) begin
            res_data <= u_out;
        end
    end

    uno_coeff_rom #(.MAC_BW(MAC_BW)) u_rom (
        .op    (op_r),
        .k     (k),
        .coeff (rom_coeff)
    );

    assign u_op      = op_r;
    assign u_x       = x_r;
    assign u_y       = y_r;
    assign u_z       = z_r;
    assign u_coeff   = (state == S_ISSUE) ? rom_coeff : '0;
    assign u_acc_en  = 1'b0;
    assign dbg_state = state;

`ifdef UNO_SEQ_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cnt <= 16'd0;
        end else if (res_fire && perf_cnt != 16'hFFFF) begin
            perf_cnt <= perf_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_uno_seq.sv
// Bench for uno_seq: random requests, behavioural uno datapath, queue scoreboard on result handshakes.
module tb_uno_seq;
    import uno_pkg::*;

    localparam int W     = 12;
    localparam int TERMS = 4;
    localparam int OW    = 2*W+4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [1:0]      req_op = 2'b00;
    logic [W-1:0]    req_x = '0, req_y = '0;
    logic [2*W-1:0]  req_z = '0;
    logic [1:0]      u_op;
    logic [W-1:0]    u_x, u_y, u_coeff;
    logic [2*W-1:0]  u_z;
    logic            u_first, u_last, u_acc_en;
    logic [OW-1:0]   u_out = '0;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic [OW-1:0]   res_data;
    state_t          dbg_state;
`ifdef UNO_SEQ_PERF_EN
    logic [15:0]     perf_cnt;
`endif

    uno_seq #(.TERMS(TERMS), .MAC_BW(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_x(req_x), .req_y(req_y), .req_z(req_z),
        .u_op(u_op), .u_x(u_x), .u_y(u_y), .u_z(u_z), .u_coeff(u_coeff),
        .u_first(u_first), .u_last(u_last), .u_acc_en(u_acc_en), .u_out(u_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
`ifdef UNO_SEQ_PERF_EN
        .perf_cnt(perf_cnt),
`endif
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Behavioural uno datapath: one registered product-sum per cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) u_out <= '0;
        else     u_out <= OW'(u_x * u_y) + OW'(u_z) + OW'(u_coeff);
    end

    // Consumer: either forced or random ready, changed just after each rising edge.
    bit rdy_mode  = 1'b0;
    bit rdy_force = 1'b1;
    always @(posedge clk) begin
        #2;
        res_ready = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_force;
    end

    // ---------------- reference model ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;
    logic [OW-1:0] exp_q[$];

    function automatic int ref_terms(input logic [1:0] op);
        return (op == 2'b00) ? 1 : TERMS;
    endfunction

    function automatic logic [W-1:0] ref_coeff(input logic [1:0] op, input int k);
        logic [W-1:0] exp_t [4];
        logic [W-1:0] geo_t [4];
        exp_t = '{12'h100, 12'h100, 12'h080, 12'h02B};
        geo_t = '{12'h100, 12'h040, 12'h010, 12'h004};
        case (op)
            2'b00:   return '0;
            2'b10:   return exp_t[k];
            default: return geo_t[k];
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                check("res_data", 32'(res_data), 32'(exp_q.pop_front()));
            end
            n_done++;
        end
    end

    // ---------------- driver ----------------
    int  last_xfer = -1;
    bit  check_gap = 1'b0;

    task automatic do_op(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [2*W-1:0] z, input int abort_k);
        int n;
        int waited;
        bit seen;
        n = ref_terms(op);
        waited = 0;
        @(negedge clk);
        while (!req_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            check("req_ready_timeout", 32'd0, 32'd1);
            return;
        end
        req_valid = 1'b1;
        req_op = op; req_x = x; req_y = y; req_z = z;
        if (abort_k < 0)
            exp_q.push_back(OW'(x * y) + OW'(z) + OW'(ref_coeff(op, n - 1)));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (check_gap && last_xfer >= 0) check("xfer_gap", 32'(cyc - last_xfer), 32'(n + 3));
        last_xfer = cyc;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check("u_first", 32'(u_first), 32'(k == 0));
            check("u_last",  32'(u_last),  32'(k == n - 1));
            check("u_coeff", 32'(u_coeff), 32'(ref_coeff(op, k)));
            check("u_op",    32'(u_op),    32'(op));
            check("u_x",     32'(u_x),     32'(x));
            check("u_acc_en", 32'(u_acc_en), 32'd0);
            if (k == abort_k) begin
                #1 rst = 1'b1;
                #1;
                check("rst_req_ready", 32'(req_ready), 32'd1);
                check("rst_res_valid", 32'(res_valid), 32'd0);
                check("rst_res_data",  32'(res_data),  32'd0);
                check("rst_u_coeff",   32'(u_coeff),   32'd0);
                check("rst_u_flags",   32'({u_first, u_last, u_acc_en}), 32'd0);
                check("rst_u_ops",     32'(u_op) | 32'(u_x) | 32'(u_y) | 32'(u_z), 32'd0);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
        end
        seen = 1'b0;
        for (int c = n + 1; c <= n + 4 && !seen; c++) begin
            @(negedge clk);
            if (res_valid) begin
                check("latency", 32'(c), 32'(n + 2));
                seen = 1'b1;
            end
        end
        if (!seen) check("res_valid_timeout", 32'd0, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    logic [OW-1:0] held;
    int            done_before;

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_res_valid", 32'(res_valid), 32'd0);
        check("reset_res_data",  32'(res_data),  32'd0);
        check("reset_u_idle",    32'(u_op) | 32'(u_x) | 32'(u_y) | 32'(u_z) | 32'(u_coeff), 32'd0);
        check("reset_u_flags",   32'({u_first, u_last}), 32'd0);

        // Directed MAC: 3*4+5 = 17.
        do_op(2'b00, 12'd3, 12'd4, 24'd5, -1);
        check("mac_17", 32'(res_data), 32'd17);

        // Directed exp with random operands: coefficient sequence checked per cycle.
        do_op(2'b10, W'($urandom), W'($urandom), (2*W)'($urandom), -1);

        // Stalled consumer: result and ready must hold, pending request ignored.
        rdy_force = 1'b0;
        repeat (2) @(negedge clk);
        do_op(2'b01, W'($urandom), W'($urandom), (2*W)'($urandom), -1);
        held = res_data;
        done_before = n_done;
        req_valid = 1'b1; req_op = 2'b11;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_res_valid", 32'(res_valid), 32'd1);
            check("stall_res_data",  32'(res_data),  32'(held));
            check("stall_req_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rdy_force = 1'b1;
        check("stall_no_pop", 32'(n_done), 32'(done_before));

        // Reset during exp issue at k=2: in-flight op discarded.
        do_op(2'b10, W'($urandom), W'($urandom), (2*W)'($urandom), 2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (res_valid) check("post_reset_res_valid", 32'd1, 32'd0);
        end
        check("post_reset_ready", 32'(req_ready), 32'd1);

        // Back-to-back with ready tied high: one request per N+3 cycles.
        check_gap = 1'b1;
        last_xfer = -1;
        for (int i = 0; i < 8; i++) begin
            do_op(2'b00, W'($urandom), W'($urandom), (2*W)'($urandom), -1);
        end
        last_xfer = -1;
        for (int i = 0; i < 4; i++) begin
            do_op(2'b01, W'($urandom), W'($urandom), (2*W)'($urandom), -1);
        end
        check_gap = 1'b0;

        // Random ops against a random consumer.
        rdy_mode = 1'b1;
        for (int i = 0; i < 30; i++) begin
            do_op(2'($urandom_range(0, 3)), W'($urandom), W'($urandom), (2*W)'($urandom), -1);
        end

        // Drain.
        begin
            int t;
            t = 0;
            while (exp_q.size() != 0 && t < 200) begin
                @(negedge clk);
                t++;
            end
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        rdy_mode = 1'b0;
`ifdef UNO_SEQ_PERF_EN
        @(negedge clk);
        check("perf_cnt", 32'(perf_cnt), 32'(n_done));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
